// File: rtl/alu_seq.sv
// alu_seq: registered ALU with a valid/ready handshake on both sides.
// Covers add/sub with carry/borrow, logic ops and barrel shifts, and
// returns the result together with the C/Z/N/V flags.
// Build option: define ALU_MUL_EN to include the iterative shift-add
// multiplier (op 10). Without it, op 10 is reported as an illegal opcode
// and result_hi always reads zero.
module alu_seq #(
    parameter int WIDTH = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cf_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             cf_out,
    output logic             zf_out,
    output logic             nf_out,
    output logic             vf_out,
    output logic             op_err
);

    // Shift amount width, derived from WIDTH.
    localparam int SHW = $clog2(WIDTH);

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_ADC = 4'd1;
    localparam logic [3:0] OP_SUB = 4'd2;
    localparam logic [3:0] OP_SBB = 4'd3;
    localparam logic [3:0] OP_AND = 4'd4;
    localparam logic [3:0] OP_OR  = 4'd5;
    localparam logic [3:0] OP_XOR = 4'd6;
    localparam logic [3:0] OP_SLL = 4'd7;
    localparam logic [3:0] OP_SRL = 4'd8;
    localparam logic [3:0] OP_SRA = 4'd9;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    state_t           state_r;
    logic             out_valid_r;
    logic [WIDTH-1:0] result_r;
    logic [WIDTH-1:0] result_hi_r;
    logic             cf_r;
    logic             zf_r;
    logic             nf_r;
    logic             vf_r;
    logic             op_err_r;

    logic             in_ready_s;
    logic             accept_s;
    logic             is_mul_s;
    logic [SHW-1:0]   shamt_s;
    logic [WIDTH:0]   ext_s;
    logic [WIDTH-1:0] alu_res_s;
    logic             alu_cf_s;
    logic             alu_vf_s;
    logic             alu_zf_s;
    logic             alu_nf_s;
    logic             alu_err_s;
    logic             mul_done_s;
    logic [WIDTH-1:0] mul_lo_s;
    logic [WIDTH-1:0] mul_hi_s;

    // A new request is taken when idle, or when the held result leaves this cycle.
    assign in_ready_s = (state_r == ST_IDLE) || ((state_r == ST_HOLD) && out_ready);
    assign accept_s   = in_valid && in_ready_s;
    assign shamt_s    = b[SHW-1:0];

    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_r;
    assign result    = result_r;
    assign result_hi = result_hi_r;
    assign cf_out    = cf_r;
    assign zf_out    = zf_r;
    assign nf_out    = nf_r;
    assign vf_out    = vf_r;
    assign op_err    = op_err_r;

`ifdef ALU_MUL_EN
    localparam logic [3:0] OP_MUL = 4'd10;
    localparam int CNT_W = $clog2(WIDTH);

    logic [2*WIDTH-1:0] prod_r;
    logic [2*WIDTH-1:0] prod_next_s;
    logic [WIDTH-1:0]   mcand_r;
    logic [CNT_W-1:0]   count_r;

    // One shift-add step: conditionally add the multiplicand to the upper
    // half, then shift the whole {carry, hi, lo} product right by one.
    function automatic logic [2*WIDTH-1:0] mul_step(
        input logic [2*WIDTH-1:0] prod,
        input logic [WIDTH-1:0]   mcand
    );
        logic [WIDTH:0] sum;
        if (prod[0]) begin
            sum = {1'b0, prod[2*WIDTH-1:WIDTH]} + {1'b0, mcand};
        end else begin
            sum = {1'b0, prod[2*WIDTH-1:WIDTH]};
        end
        return {sum, prod[WIDTH-1:1]};
    endfunction

    assign is_mul_s    = (op == OP_MUL);
    assign prod_next_s = mul_step(prod_r, mcand_r);
    assign mul_done_s  = (state_r == ST_BUSY) && (count_r == CNT_W'(1));
    assign mul_lo_s    = prod_next_s[WIDTH-1:0];
    assign mul_hi_s    = prod_next_s[2*WIDTH-1:WIDTH];

    // Multiplier datapath: the first step is folded into the accept edge so
    // the product is ready WIDTH edges after acceptance; count tracks the
    // steps still to go and the step taken at count 1 is the last one.
    always_ff @(posedge clock) begin
        if (reset) begin
            prod_r  <= {(2*WIDTH){1'b0}};
            mcand_r <= {WIDTH{1'b0}};
            count_r <= {CNT_W{1'b0}};
        end else if (accept_s && is_mul_s) begin
            prod_r  <= mul_step({{WIDTH{1'b0}}, b}, a);
            mcand_r <= a;
            count_r <= CNT_W'(WIDTH - 1);
        end else if (state_r == ST_BUSY) begin
            prod_r  <= prod_next_s;
            count_r <= count_r - CNT_W'(1);
        end else begin
            prod_r  <= prod_r;
            mcand_r <= mcand_r;
            count_r <= count_r;
        end
    end
`else
    assign is_mul_s   = 1'b0;
    assign mul_done_s = 1'b0;
    assign mul_lo_s   = {WIDTH{1'b0}};
    assign mul_hi_s   = {WIDTH{1'b0}};
`endif

    // Single-cycle ALU: all non-multiply results and their flags.
    always_comb begin
        ext_s     = {(WIDTH+1){1'b0}};
        alu_res_s = {WIDTH{1'b0}};
        alu_cf_s  = 1'b0;
        alu_vf_s  = 1'b0;
        alu_err_s = 1'b0;
        case (op)
            OP_ADD, OP_ADC: begin
                ext_s     = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, (op == OP_ADC) & cf_in};
                alu_res_s = ext_s[WIDTH-1:0];
                alu_cf_s  = ext_s[WIDTH];
                alu_vf_s  = (a[WIDTH-1] == b[WIDTH-1]) && (ext_s[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB, OP_SBB: begin
                // Bit WIDTH of the extended difference is the borrow.
                ext_s     = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, (op == OP_SBB) & cf_in};
                alu_res_s = ext_s[WIDTH-1:0];
                alu_cf_s  = ext_s[WIDTH];
                alu_vf_s  = (a[WIDTH-1] != b[WIDTH-1]) && (ext_s[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND: alu_res_s = a & b;
            OP_OR:  alu_res_s = a | b;
            OP_XOR: alu_res_s = a ^ b;
            OP_SLL: begin
                // The extra top bit catches the last bit shifted out.
                ext_s     = {1'b0, a} << shamt_s;
                alu_res_s = ext_s[WIDTH-1:0];
                alu_cf_s  = ext_s[WIDTH];
            end
            OP_SRL: begin
                ext_s     = {a, 1'b0} >> shamt_s;
                alu_res_s = ext_s[WIDTH:1];
                alu_cf_s  = ext_s[0];
            end
            OP_SRA: begin
                ext_s     = $unsigned($signed({a, 1'b0}) >>> shamt_s);
                alu_res_s = ext_s[WIDTH:1];
                alu_cf_s  = ext_s[0];
            end
`ifdef ALU_MUL_EN
            OP_MUL: alu_err_s = 1'b0;
`endif
            default: alu_err_s = 1'b1;
        endcase
        alu_zf_s = (alu_res_s == {WIDTH{1'b0}});
        alu_nf_s = alu_res_s[WIDTH-1];
    end

    // Control FSM and the registered result/flag outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            out_valid_r <= 1'b0;
            result_r    <= {WIDTH{1'b0}};
            result_hi_r <= {WIDTH{1'b0}};
            cf_r        <= 1'b0;
            zf_r        <= 1'b0;
            nf_r        <= 1'b0;
            vf_r        <= 1'b0;
            op_err_r    <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE, ST_HOLD: begin
                    if (accept_s && is_mul_s) begin
                        state_r     <= ST_BUSY;
                        out_valid_r <= 1'b0;
                    end else if (accept_s) begin
                        state_r     <= ST_HOLD;
                        out_valid_r <= 1'b1;
                        result_r    <= alu_res_s;
                        result_hi_r <= {WIDTH{1'b0}};
                        cf_r        <= alu_cf_s;
                        zf_r        <= alu_zf_s;
                        nf_r        <= alu_nf_s;
                        vf_r        <= alu_vf_s;
                        op_err_r    <= alu_err_s;
                    end else if ((state_r == ST_HOLD) && out_ready) begin
                        state_r     <= ST_IDLE;
                        out_valid_r <= 1'b0;
                    end else begin
                        state_r     <= state_r;
                        out_valid_r <= out_valid_r;
                    end
                end
                ST_BUSY: begin
                    if (mul_done_s) begin
                        state_r     <= ST_HOLD;
                        out_valid_r <= 1'b1;
                        result_r    <= mul_lo_s;
                        result_hi_r <= mul_hi_s;
                        cf_r        <= (mul_hi_s != {WIDTH{1'b0}});
                        zf_r        <= (mul_hi_s == {WIDTH{1'b0}}) && (mul_lo_s == {WIDTH{1'b0}});
                        nf_r        <= mul_lo_s[WIDTH-1];
                        vf_r        <= 1'b0;
                        op_err_r    <= 1'b0;
                    end else begin
                        state_r     <= ST_BUSY;
                        out_valid_r <= 1'b0;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, registered successor to the CPU's combinational ALU.
- Accepts one operation per handshake: add/sub with carry/borrow, logic ops, barrel shifts, and an optional iterative shift-add multiply.
- Returns a registered result plus a full flag set (C/Z/N/V) over a valid/ready handshake.
- Sits between the EX-stage operand latches and the writeback/flag register; the flags are computed here, not in the CPU.

Parameters:
- WIDTH, 16, operand/result width in bits (>=4).
- SHW, $clog2(WIDTH), number of low bits of b used as the shift amount (derived, not overridden).

Ports:
- clock  in  1  system clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  operation request.
- in_ready  out  1  block can accept a request this cycle.
- op  in  4  operation code, listed under Behaviour.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B; for shifts, b[SHW-1:0] is the shift amount.
- cf_in  in  1  carry/borrow in, used by ADC/SBB only.
- out_valid  out  1  result registers hold a valid result.
- out_ready  in  1  consumer takes the result.
- result  out  WIDTH  result, or the low half of the product for MUL.
- result_hi  out  WIDTH  high half of the product for MUL; 0 for every other op.
- cf_out, zf_out, nf_out, vf_out  out  1 each  carry, zero, negative and signed-overflow flags.
- op_err  out  1  request carried an illegal or disabled opcode.

Behaviour:
- Reset (synchronous, dominant over all other inputs): state=IDLE; out_valid, result, result_hi, all flags and op_err = 0; MUL counter = 0.
- Reset asserted mid-MUL aborts the multiply; no result is produced.
- Opcodes:
  - 0 ADD: a+b.
  - 1 ADC: a+b+cf_in.
  - 2 SUB: a-b.
  - 3 SBB: a-b-cf_in.
  - 4 AND, 5 OR, 6 XOR.
  - 7 SLL, 8 SRL (zero fill), 9 SRA (sign fill).
  - 10 MUL: unsigned WIDTH x WIDTH into {result_hi,result}.
  - 11-15: illegal.
- Arithmetic: computed at WIDTH+1 bits.
  - ADD/ADC: cf = carry-out.
  - SUB/SBB: cf = borrow (1 when the unsigned a < b + cin).
  - vf = signed overflow for add/sub; vf = 0 for every other op.
- Shifts:
  - Amount n = b[SHW-1:0]; upper bits of b are ignored.
  - cf = last bit shifted out; n=0 -> result=a, cf=0.
- Logic ops: cf=0.
- MUL: cf = (result_hi != 0).
- Flags for all ops: zf = (result==0); nf = result[WIDTH-1]. For MUL, zf covers the full product.
- Illegal opcode: result=0, result_hi=0, zf=1, all other flags 0, op_err=1, latency 1.
- State machine:
  - IDLE: in_ready=1. A request accepted with op!=MUL -> result registered at the next edge, go to HOLD. MUL -> load multiplicand/multiplier, count=WIDTH, go to BUSY.
  - BUSY: in_ready=0. One shift-add step per cycle; count decrements. When count reaches 1, the final step is written and the block goes to HOLD. MUL latency is WIDTH cycles from acceptance to out_valid.
  - HOLD: out_valid=1; result, flags and op_err stay stable until out_ready=1.
  - HOLD with out_ready=1 and no new request -> IDLE, out_valid drops.
- Back-to-back: in_ready = IDLE | (HOLD & out_ready). In HOLD with out_ready=1 and in_valid=1, the new request is accepted in the same cycle. Non-MUL requests give one result per cycle; MUL goes to BUSY.
- Inputs a, b, op and cf_in are sampled only on the accept cycle; changes during BUSY/HOLD have no effect.
- out_ready while out_valid=0 is ignored.

Optional Feature:
- ALU_MUL_EN defined: MUL (op 10) behaves as specified; BUSY state and counter are present.
- ALU_MUL_EN undefined: BUSY logic is not built; op 10 is treated as illegal (op_err=1, latency 1); result_hi is tied to 0.

Test Plan:
- WIDTH=16. Reset held 2 cycles -> out_valid=0, result=0, all flags=0, in_ready=1. Apply in_valid during reset -> no capture.
- ADD a=16'h7FFF, b=1 -> result 16'h8000, vf=1, nf=1, cf=0, zf=0, one cycle after accept. SBB a=0, b=0, cf_in=1 -> 16'hFFFF, cf=1, nf=1.
- SRA a=16'h8001, b=16'h0011 (n=1, upper bits ignored) -> 16'hC000, cf=1. SLL with n=0 -> result=a, cf=0.
- MUL a=16'h0100, b=16'h0300 (ALU_MUL_EN defined) -> out_valid after exactly 16 cycles; result_hi=16'h0003, result=0, cf=1, zf=0. Same test with the macro undefined -> op_err=1 after 1 cycle.
- Backpressure: hold out_ready=0 for 5 cycles with in_valid=1 -> result stable, in_ready=0, no new accept. Then out_ready=1 with a new ADD -> accepted in the same cycle, next result on the next edge.
- Reset asserted at cycle 7 of a MUL -> IDLE next cycle; out_valid never rises for the aborted op. A following AND 16'hF0F0 & 16'h0FF0 -> 16'h00F0.
